inst_sram_resp: RTL

Instruction-side SRAM responder. It sits behind the fetch stage and answers its SRAM-style requests (`inst_sram_en`, `inst_sram_we`, `inst_sram_addr`, `inst_sram_wdata`) with `inst_sram_rdata`, using SRAM read timing: data is valid one cycle after the request. It keeps a one-entry 64-bit line buffer for back-to-back fetches from the same doubleword. On a miss, it issues a valid/ready transaction to backing memory and raises a stall request to the pipeline controller until the data returns.

---
 rtl/mycpu_pkg.sv | 20 ++
 rtl/line_buf.sv | 47 ++++
 rtl/inst_sram_resp.sv | 123 ++++++++++++
 3 files changed

// File: rtl/mycpu_pkg.sv
// Shared definitions for the instruction- and data-side SRAM responders:
// responder state encoding, line geometry and the backing-memory request record.
package mycpu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } resp_state_t;

   localparam int LINE_OFF_W = 3;

   typedef struct packed {
      logic        valid;
      logic [63:0] addr;
      logic [7:0]  wstrb;
      logic [63:0] wdata;
   } mem_req_t;

endpackage

// File: rtl/line_buf.sv
// One-entry line buffer: tag/data register with hit compare, fill from memory
// and a byte-merge port so buffered lines stay coherent with fetch-side writes.
module line_buf
   import mycpu_pkg::*;
#(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64,
   parameter bit EN     = 1'b1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [ADDR_W-LINE_OFF_W-1:0] lookup_line_i,
   output logic                         hit_o,
   output logic [DATA_W-1:0]            data_o,
   input  logic                         fill_i,
   input  logic [ADDR_W-LINE_OFF_W-1:0] fill_line_i,
   input  logic [DATA_W-1:0]            fill_data_i,
   input  logic                         merge_i,
   input  logic [7:0]                   merge_strb_i,
   input  logic [DATA_W-1:0]            merge_data_i
);

   logic                         valid_q;
   logic [ADDR_W-LINE_OFF_W-1:0] tag_q;
   logic [DATA_W-1:0]            data_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         tag_q   <= '0;
         data_q  <= '0;
      end else if (fill_i) begin
         // With the buffer disabled a fill never becomes valid, so every read misses.
         valid_q <= EN;
         tag_q   <= fill_line_i;
         data_q  <= fill_data_i;
      end else if (merge_i) begin
         for (int i = 0; i < 8; i++) begin
            if (merge_strb_i[i]) data_q[i*8 +: 8] <= merge_data_i[i*8 +: 8];
         end
      end
   end

   assign hit_o  = EN && valid_q && (tag_q == lookup_line_i);
   assign data_o = data_q;

endmodule

// File: rtl/inst_sram_resp.sv
// Instruction-side SRAM responder: answers fetch requests with one-cycle SRAM
// read timing, serving line-buffer hits directly and stalling IF on misses/writes.
//
// state | meaning
// IDLE  | accepting requests; hits served from the line buffer
// REQ   | mem_req_valid high, request fields held until mem_req_ready
// WAIT  | read handshaken, waiting for mem_resp_valid
module inst_sram_resp
   import mycpu_pkg::*;
#(
   parameter int ADDR_W  = 64,
   parameter int DATA_W  = 64,
   parameter bit LBUF_EN = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              inst_sram_en,
   input  logic [7:0]        inst_sram_we,
   input  logic [ADDR_W-1:0] inst_sram_addr,
   input  logic [DATA_W-1:0] inst_sram_wdata,
   output logic [DATA_W-1:0] inst_sram_rdata,
   output logic              stallreq_if,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [ADDR_W-1:0] mem_req_addr,
   output logic [7:0]        mem_req_wstrb,
   output logic [DATA_W-1:0] mem_req_wdata,
   input  logic              mem_resp_valid,
   input  logic [DATA_W-1:0] mem_resp_data
);

   localparam int LINE_W = ADDR_W - LINE_OFF_W;

   resp_state_t       state_q, state_d;
   logic [DATA_W-1:0] rdata_q;
   logic [LINE_W-1:0] line_q;
   logic [7:0]        wstrb_q;
   logic [DATA_W-1:0] wdata_q;

   logic [LINE_W-1:0] req_line;
   logic              lb_hit;
   logic [DATA_W-1:0] lb_data;
   logic              acc_rd, acc_wr, resp_take;
   logic              unused_addr_off;

   assign req_line        = inst_sram_addr[ADDR_W-1:LINE_OFF_W];
   assign unused_addr_off = ^inst_sram_addr[LINE_OFF_W-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (inst_sram_en && ((inst_sram_we != 8'h00) || !lb_hit)) state_d = REQ;
         REQ:  if (mem_req_ready) state_d = (wstrb_q == 8'h00) ? WAIT : IDLE;
         WAIT: if (mem_resp_valid) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      stallreq_if   = 1'b1;
      mem_req_valid = 1'b0;
      acc_rd        = 1'b0;
      acc_wr        = 1'b0;
      resp_take     = 1'b0;
      case (state_q)
         IDLE: begin
            stallreq_if = 1'b0;
            acc_rd      = inst_sram_en && (inst_sram_we == 8'h00);
            acc_wr      = inst_sram_en && (inst_sram_we != 8'h00);
         end
         REQ:  mem_req_valid = 1'b1;
         WAIT: resp_take     = mem_resp_valid;
         default: ;
      endcase
   end

   // Request fields only load in IDLE, so they are stable for the whole REQ phase.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_q <= '0;
         line_q  <= '0;
         wstrb_q <= '0;
         wdata_q <= '0;
      end else begin
         if (acc_rd && lb_hit) rdata_q <= lb_data;
         if (resp_take)        rdata_q <= mem_resp_data;
         if ((acc_rd && !lb_hit) || acc_wr) begin
            line_q  <= req_line;
            wstrb_q <= inst_sram_we;
         end
         if (acc_wr) wdata_q <= inst_sram_wdata;
      end
   end

   line_buf #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .EN     (LBUF_EN)
   ) u_line_buf (
      .clk           (clk),
      .rst           (rst),
      .lookup_line_i (req_line),
      .hit_o         (lb_hit),
      .data_o        (lb_data),
      .fill_i        (resp_take),
      .fill_line_i   (line_q),
      .fill_data_i   (mem_resp_data),
      .merge_i       (acc_wr && lb_hit),
      .merge_strb_i  (inst_sram_we),
      .merge_data_i  (inst_sram_wdata)
   );

   assign inst_sram_rdata = rdata_q;
   assign mem_req_addr    = {line_q, {LINE_OFF_W{1'b0}}};
   assign mem_req_wstrb   = wstrb_q;
   assign mem_req_wdata   = wdata_q;

endmodule
